// File: rtl/phase_deg_calc.sv
// Converts a phase-difference count and gate-window count into 0.1 degree units
// using a one-bit-per-clock restoring divider. Optional rounding: PHASE_ROUND_EN.
//
// state | meaning
// IDLE  | waiting for in_valid, inputs captured on acceptance
// LOAD  | build dividend phase_cnt*3600, set up divisor and iteration count
// DIV   | one quotient bit per clock, DIV_W clocks
// DONE  | result registered, out_valid high
module phase_deg_calc #(
    parameter int CNT_W = 32,
    parameter int OUT_W = 12
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] phase_cnt,
    input  logic [CNT_W-1:0] ref_cnt,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] phase_deg10,
    output logic             div_err,
    output logic             range_err
);

    localparam int DIV_W = CNT_W + 13;
    localparam int REM_W = CNT_W + 1;
    localparam int IT_W  = $clog2(DIV_W);
    localparam logic [OUT_W-1:0] DEG_MAX = OUT_W'(3599);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_q, ref_q;
    logic [DIV_W-1:0] dq;
    logic [REM_W-1:0] rem;
    logic [IT_W-1:0]  iter;
    logic             div_err_q, range_err_q;

    logic             capture, last_step;
    logic [DIV_W-1:0] phase_ext, dividend;
    logic [REM_W-1:0] rem_sh, rem_nxt;
    logic             rem_ge;
    logic [DIV_W-1:0] dq_nxt;
    logic [OUT_W-1:0] result;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (iter == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        capture   = (state == IDLE) && in_valid;
        last_step = (state == DIV) && (iter == '0);
    end

    // 3600 = 2048 + 1024 + 512 + 16
    always_comb begin
        phase_ext = {{(DIV_W-CNT_W){1'b0}}, phase_q};
        dividend  = (phase_ext << 11) + (phase_ext << 10) + (phase_ext << 9) + (phase_ext << 4);
`ifdef PHASE_ROUND_EN
        dividend  = dividend + {{(DIV_W-CNT_W+1){1'b0}}, ref_q[CNT_W-1:1]};
`endif
    end

    // Remainder stays below the divisor, so dropping its MSB on the shift loses nothing.
    always_comb begin
        rem_sh  = {rem[REM_W-2:0], dq[DIV_W-1]};
        rem_ge  = (rem_sh >= {1'b0, ref_q});
        rem_nxt = rem_ge ? (rem_sh - {1'b0, ref_q}) : rem_sh;
        dq_nxt  = {dq[DIV_W-2:0], rem_ge};
    end

    always_comb begin
        result = dq_nxt[OUT_W-1:0];
`ifdef PHASE_ROUND_EN
        if (dq_nxt == DIV_W'(3600)) result = '0;
`endif
        if (div_err_q)        result = '0;
        else if (range_err_q) result = DEG_MAX;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            ref_q       <= '0;
            dq          <= '0;
            rem         <= '0;
            iter        <= '0;
            div_err_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (capture) begin
                phase_q <= phase_cnt;
                ref_q   <= ref_cnt;
            end
            if (state == LOAD) begin
                dq          <= dividend;
                rem         <= '0;
                iter        <= IT_W'(DIV_W - 1);
                div_err_q   <= (ref_q == '0);
                range_err_q <= (ref_q != '0) && (phase_q >= ref_q);
            end else if (state == DIV) begin
                dq   <= dq_nxt;
                rem  <= rem_nxt;
                iter <= iter - 1'b1;
            end
        end
    end

    // Result registers hold until the next conversion completes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            phase_deg10 <= '0;
            div_err     <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            out_valid <= last_step;
            if (last_step) begin
                phase_deg10 <= result;
                div_err     <= div_err_q;
                range_err   <= range_err_q;
            end
        end
    end

endmodule

// File: tb/tb_phase_deg_calc.sv
// Directed self-checking bench for phase_deg_calc; expected values are hand-computed.
module tb_phase_deg_calc;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] phase_cnt;
    logic [31:0] ref_cnt;
    logic        busy;
    logic        out_valid;
    logic [11:0] phase_deg10;
    logic        div_err;
    logic        range_err;

    int checks = 0;
    int errors = 0;

`ifdef PHASE_ROUND_EN
    localparam int EXP_2_7    = 1029;
    localparam int EXP_19999  = 0;
`else
    localparam int EXP_2_7    = 1028;
    localparam int EXP_19999  = 3599;
`endif

    phase_deg_calc dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .phase_cnt   (phase_cnt),
        .ref_cnt     (ref_cnt),
        .busy        (busy),
        .out_valid   (out_valid),
        .phase_deg10 (phase_deg10),
        .div_err     (div_err),
        .range_err   (range_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] pc, input logic [31:0] rc);
        phase_cnt = pc;
        ref_cnt   = rc;
        in_valid  = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        while (lat < 100) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (busy) bsy++;
            if (out_valid) break;
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] pc, input logic [31:0] rc,
                           input int exp_deg, input int exp_de, input int exp_re);
        int lat, bsy;
        start(pc, rc);
        wait_done(lat, bsy);
        check({tag, " latency"}, lat, 46);
        check({tag, " busy cycles"}, bsy, 46);
        check({tag, " deg"}, phase_deg10, exp_deg);
        check({tag, " div_err"}, div_err, exp_de);
        check({tag, " range_err"}, range_err, exp_re);
        @(posedge sys_clk);
        #1;
        check({tag, " strobe width"}, out_valid, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " hold deg"}, phase_deg10, exp_deg);
    endtask

    initial begin
        int lat, bsy, pulses, last_deg;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        phase_cnt = '0;
        ref_cnt   = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset deg", phase_deg10, 0);
        check("reset div_err", div_err, 0);
        check("reset range_err", range_err, 0);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        convert("quarter", 32'd100_000_000, 32'd400_000_000, 900, 0, 0);
        convert("two_sevenths", 32'd2, 32'd7, EXP_2_7, 0, 0);
        convert("near_full", 32'd19_999, 32'd20_000, EXP_19999, 0, 0);
        convert("ref_zero", 32'd12_345, 32'd0, 0, 1, 0);
        convert("equal", 32'd5000, 32'd5000, 3599, 0, 1);
        convert("clear_flags", 32'd1, 32'd4, 900, 0, 0);

        // Second request mid-conversion must be dropped.
        start(32'd100_000_000, 32'd400_000_000);
        repeat (9) @(posedge sys_clk);
        #1;
        phase_cnt = 32'd2;
        ref_cnt   = 32'd7;
        in_valid  = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid  = 1'b0;
        pulses    = 0;
        last_deg  = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk);
            #1;
            if (out_valid) begin
                pulses++;
                last_deg = phase_deg10;
            end
        end
        check("ignore pulses", pulses, 1);
        check("ignore deg", last_deg, 900);
        check("ignore busy", busy, 0);

        // Reset 20 cycles into a conversion.
        start(32'd2, 32'd7);
        repeat (19) @(posedge sys_clk);
        #1;
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort deg", phase_deg10, 0);
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort no strobe", pulses, 0);
        convert("post_reset", 32'd100_000_000, 32'd400_000_000, 900, 0, 0);

        // convert() returns in the first IDLE cycle after DONE.
        start(32'd1, 32'd3);
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
        end
        check("b2b busy", busy, 1);
        check("b2b hold deg", phase_deg10, 900);
        wait_done(lat, bsy);
        check("b2b latency", lat, 26);
        check("b2b deg", phase_deg10, 1200);
        check("b2b flags", {div_err, range_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phase_deg_calc.md
Name: phase_deg_calc

Overview:
- Downstream consumer of the phase-difference counter.
- Converts the latched phase-difference clock count and the gate-window clock count into a phase angle in units of 0.1° (0..3599).
- Uses a multicycle shift-subtract divider, one quotient bit per clock.
- The result feeds the display/UART formatting stage with a one-cycle valid strobe.

Parameters:
- CNT_W, 32, width of `phase_cnt` and `ref_cnt` inputs.
- OUT_W, 12, width of the phase result; fixed by the 0..3599 range, do not reduce.

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  one-cycle strobe: `phase_cnt` and `ref_cnt` are stable and a new conversion is requested.
- `phase_cnt`  in  CNT_W  clocks during which sig_in0 leads sig_in1 within one gate window.
- `ref_cnt`  in  CNT_W  total clocks in the same gate window (nominal 400_000_000).
- `busy`  out  1  high while a conversion is in progress.
- `out_valid`  out  1  one-cycle strobe; a new result is on `phase_deg10` and the flags.
- `phase_deg10`  out  OUT_W  phase in 0.1° units, 0..3599.
- `div_err`  out  1  last conversion had `ref_cnt == 0`.
- `range_err`  out  1  last conversion had `phase_cnt >= ref_cnt`.

Behaviour:
- Reset (async, `rst_n` low): all outputs 0, FSM to IDLE, internal registers cleared. Reset mid-conversion aborts it; no `out_valid` is produced.
- FSM states: IDLE, LOAD, DIV, DONE.
- IDLE:
  - `busy` = 0.
  - `in_valid` = 1 at an edge captures both inputs and goes to LOAD.
  - `in_valid` while not in IDLE is ignored; no queueing.
- LOAD (1 cycle):
  - Dividend D = `phase_cnt` * 3600, computed as shifts/adds (3600 = 2048+1024+512+16), width DIV_W = CNT_W+13.
  - Divisor = captured `ref_cnt`. Remainder cleared, iteration counter = DIV_W-1.
  - Go to DIV.
- DIV (DIV_W cycles):
  - Each cycle: remainder = {remainder, next dividend MSB}. If remainder >= divisor, subtract it and shift in 1; else shift in 0.
  - The counter decrements each cycle; when it reaches 0, go to DONE.
- DONE (1 cycle):
  - Register outputs, pulse `out_valid` = 1, return to IDLE.
  - `busy` is high in LOAD, DIV and DONE.
- Latency:
  - `in_valid` sampled at edge k → `out_valid` high for exactly the cycle after edge k+DIV_W+1 (46 cycles at defaults).
  - Fixed latency in all cases, including error cases.
  - The next `in_valid` is accepted no earlier than the edge after DONE.
- Result rules, in priority order:
  - `ref_cnt == 0`: `phase_deg10` = 0, `div_err` = 1, `range_err` = 0.
  - `phase_cnt >= ref_cnt`: `phase_deg10` = 3599, `range_err` = 1, `div_err` = 0.
  - Otherwise: `phase_deg10` = quotient (always <= 3599 without rounding); both flags 0.
- Outputs and flags hold their values between `out_valid` strobes.
- Divider arithmetic is unsigned; the remainder register is CNT_W+1 bits so the compare never overflows.

Optional Feature:
- Macro: `PHASE_ROUND_EN`.
- Defined:
  - LOAD adds `ref_cnt` >> 1 to D, giving round-to-nearest.
  - A quotient of exactly 3600 with `phase_cnt < ref_cnt` wraps to 0, with no flag.
- Undefined: truncating division, no add.
- Latency and DIV_W are identical in both builds.

Test Plan:
- `phase_cnt` = 100_000_000, `ref_cnt` = 400_000_000, `in_valid` pulse → after 46 cycles `out_valid` = 1, `phase_deg10` = 900, flags 0.
- `phase_cnt` = 2, `ref_cnt` = 7 → 1028 without `PHASE_ROUND_EN`, 1029 with it. `phase_cnt` = 19_999, `ref_cnt` = 20_000 → 3599 without, 0 with; flags 0 in both builds.
- `ref_cnt` = 0, any `phase_cnt` → `phase_deg10` = 0, `div_err` = 1. `phase_cnt` = `ref_cnt` = 5000 → `phase_deg10` = 3599, `range_err` = 1. Both cases keep 46-cycle latency.
- `in_valid` pulsed again 10 cycles into a conversion with different data → ignored. Exactly one `out_valid`, carrying the first data's result; `busy` high for 46 cycles.
- `rst_n` low for 1 cycle, 20 cycles into a conversion → outputs 0 immediately, no `out_valid` follows. A new `in_valid` after reset converts normally.
- Back-to-back: `in_valid` pulsed in the first IDLE cycle after DONE with `phase_cnt` = 1, `ref_cnt` = 3 → accepted, `phase_deg10` = 1200. The previous result holds until this `out_valid`.
